// File: rtl/pattern_seq_pkg.sv
// -----------------------------------------------------------------------------
// pattern_seq_pkg
// Shared types and defaults for the pattern sequencer:
//   state_e      - sequencer FSM states (IDLE / RUN / DONE)
//   IDLE_PAT_DEF - pattern driven while not running
//   entry_t      - table entry {pat, dwell} at the default dwell width
//   *_DEF        - default table depth, dwell width and loop counter width
// -----------------------------------------------------------------------------
package pattern_seq_pkg;

    localparam int          DEPTH_DEF    = 8;
    localparam int          DWELL_W_DEF  = 8;
    localparam int          LOOP_W_DEF   = 4;
    localparam logic [2:0]  IDLE_PAT_DEF = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]             pat;
        logic [DWELL_W_DEF-1:0] dwell;
    } entry_t;

endpackage

// File: rtl/pattern_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pattern_seq_ctrl_if
// Bundles the configuration/command inputs and the pattern outputs of the
// sequencer.
//   master modport: command/config source (drives cfg_*, loops, start, stop;
//                   observes pat, step, busy, done)
//   slave modport : the sequencer itself
// -----------------------------------------------------------------------------
interface pattern_seq_ctrl_if
    import pattern_seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int LOOP_W  = LOOP_W_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [2:0]         cfg_pat;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [AW-1:0]      cfg_len;
    logic [LOOP_W-1:0]  loops;
    logic               start;
    logic               stop;
    logic [2:0]         pat;
    logic [AW-1:0]      step;
    logic               busy;
    logic               done;

    modport master (
        output cfg_we, cfg_addr, cfg_pat, cfg_dwell, cfg_len, loops, start, stop,
        input  pat, step, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_pat, cfg_dwell, cfg_len, loops, start, stop,
        output pat, step, busy, done
    );

endinterface

// File: rtl/pattern_seq_ctrl_table.sv
// -----------------------------------------------------------------------------
// pattern_table
// DEPTH-entry register file holding {pat, dwell} per step.
//   i_clk, i_rst      - clock, synchronous active-high reset (clears entries)
//   i_we, i_busy      - write strobe; writes are dropped while i_busy is high
//   i_waddr/i_wpat/i_wdwell - write address and data
//   i_raddr           - asynchronous read address (next-step index)
//   o_rpat/o_rdwell   - read data
// -----------------------------------------------------------------------------
module pattern_table
    import pattern_seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic                     i_busy,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [2:0]               i_wpat,
    input  logic [DWELL_W-1:0]       i_wdwell,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [2:0]               o_rpat,
    output logic [DWELL_W-1:0]       o_rdwell
);

    typedef struct packed {
        logic [2:0]         pat;
        logic [DWELL_W-1:0] dwell;
    } seq_entry_t;

    seq_entry_t r_mem [DEPTH];

    // Table storage: cleared by reset, written only while the sequencer is not running.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && !i_busy) begin
            r_mem[i_waddr] <= {i_wpat, i_wdwell};
        end
    end

    assign o_rpat   = r_mem[i_raddr].pat;
    assign o_rdwell = r_mem[i_raddr].dwell;

endmodule

// File: rtl/pattern_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_seq_ctrl
// Programmable 3-bit pattern sequencer. Steps through table entries 0..len,
// holding each for dwell+1 cycles, repeating the pass `loops` times
// (0 = forever), then pulses done for one cycle.
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset (outputs, FSM and table)
//   bus  - pattern_seq_ctrl_if.slave: cfg_we/cfg_addr/cfg_pat/cfg_dwell table
//          writes, cfg_len/loops/start/stop commands, registered pat/step/
//          busy/done outputs
// -----------------------------------------------------------------------------
module pattern_seq_ctrl
    import pattern_seq_pkg::*;
#(
    parameter int         DEPTH    = DEPTH_DEF,
    parameter int         DWELL_W  = DWELL_W_DEF,
    parameter int         LOOP_W   = LOOP_W_DEF,
    parameter logic [2:0] IDLE_PAT = IDLE_PAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pattern_seq_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e             r_state, w_state_nxt;
    logic [2:0]         r_pat, w_pat_nxt;
    logic [AW-1:0]      r_step, w_step_nxt;
    logic [AW-1:0]      r_len, w_len_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic [LOOP_W-1:0]  r_loop, w_loop_nxt;
    logic               r_inf, w_inf_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;

    logic [AW-1:0]      w_rd_addr;
    logic [2:0]         w_tbl_pat;
    logic [DWELL_W-1:0] w_tbl_dwell;
    logic               w_go;
    logic               w_step_end;
    logic               w_more_steps;
    logic               w_final;

    pattern_table #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) u_table (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_we     (bus.cfg_we),
        .i_busy   (r_busy),
        .i_waddr  (bus.cfg_addr),
        .i_wpat   (bus.cfg_pat),
        .i_wdwell (bus.cfg_dwell),
        .i_raddr  (w_rd_addr),
        .o_rpat   (w_tbl_pat),
        .o_rdwell (w_tbl_dwell)
    );

    // Step/pass decode shared by the next-state and datapath logic.
    always_comb begin
        w_go         = bus.start && !bus.stop;
        w_step_end   = (r_dwell == {DWELL_W{1'b0}});
        w_more_steps = (r_step < r_len);
        // Last cycle of the last pass of a finite run; the loop counter sits at 1 there.
        w_final      = w_step_end && !w_more_steps && !r_inf && (r_loop <= LOOP_W'(1));
    end

    // Table read address: the entry loaded on the next step change (step+1, or 0 on start/wrap).
    always_comb begin
        if ((r_state == ST_RUN) && w_more_steps) begin
            w_rd_addr = r_step + AW'(1);
        end else begin
            w_rd_addr = {AW{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; stop has priority over everything in IDLE and RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_final) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output/datapath logic: next values for pattern, step, counters and flags.
    always_comb begin
        w_pat_nxt   = r_pat;
        w_step_nxt  = r_step;
        w_len_nxt   = r_len;
        w_dwell_nxt = r_dwell;
        w_loop_nxt  = r_loop;
        w_inf_nxt   = r_inf;
        w_busy_nxt  = (w_state_nxt == ST_RUN);
        w_done_nxt  = (w_state_nxt == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    // Read happens before this edge's table write, so step 0 sees pre-write data.
                    w_pat_nxt   = w_tbl_pat;
                    w_step_nxt  = {AW{1'b0}};
                    w_dwell_nxt = w_tbl_dwell;
                    w_loop_nxt  = bus.loops;
                    w_len_nxt   = bus.cfg_len;
                    w_inf_nxt   = (bus.loops == {LOOP_W{1'b0}});
                end else begin
                    w_pat_nxt  = IDLE_PAT;
                    w_step_nxt = {AW{1'b0}};
                end
            end
            ST_RUN: begin
                if (bus.stop || w_final) begin
                    w_pat_nxt  = IDLE_PAT;
                    w_step_nxt = {AW{1'b0}};
                end else if (!w_step_end) begin
                    w_dwell_nxt = r_dwell - DWELL_W'(1);
                end else if (w_more_steps) begin
                    w_step_nxt  = r_step + AW'(1);
                    w_pat_nxt   = w_tbl_pat;
                    w_dwell_nxt = w_tbl_dwell;
                end else begin
                    // End of a non-final pass: wrap to entry 0 with no gap cycle.
                    w_step_nxt  = {AW{1'b0}};
                    w_pat_nxt   = w_tbl_pat;
                    w_dwell_nxt = w_tbl_dwell;
                    if (!r_inf) begin
                        w_loop_nxt = r_loop - LOOP_W'(1);
                    end else begin
                        w_loop_nxt = r_loop;
                    end
                end
            end
            ST_DONE: begin
                w_pat_nxt  = IDLE_PAT;
                w_step_nxt = {AW{1'b0}};
            end
            default: begin
                w_pat_nxt  = IDLE_PAT;
                w_step_nxt = {AW{1'b0}};
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat   <= IDLE_PAT;
            r_step  <= {AW{1'b0}};
            r_len   <= {AW{1'b0}};
            r_dwell <= {DWELL_W{1'b0}};
            r_loop  <= {LOOP_W{1'b0}};
            r_inf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pat   <= w_pat_nxt;
            r_step  <= w_step_nxt;
            r_len   <= w_len_nxt;
            r_dwell <= w_dwell_nxt;
            r_loop  <= w_loop_nxt;
            r_inf   <= w_inf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.pat  = r_pat;
    assign bus.step = r_step;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_seq_ctrl
// Directed bench for pattern_seq_ctrl. A bench-side copy of the table expands
// each run into per-cycle expected {pat, step, busy, done} samples which are
// queued when stimulus is applied and popped one per clock, 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_pattern_seq_ctrl;

    localparam logic [2:0] IDLE_PAT = 3'b101;

    typedef struct packed {
        logic [2:0] pat;
        logic [2:0] step;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk;
    logic rst;

    obs_t       sb [$];
    logic [2:0] m_pat   [8];
    int         m_dwell [8];
    int         n_cmp  = 0;
    int         n_fail = 0;

    pattern_seq_ctrl_if #(.DEPTH(8), .DWELL_W(8), .LOOP_W(4)) bus ();

    pattern_seq_ctrl #(
        .DEPTH    (8),
        .DWELL_W  (8),
        .LOOP_W   (4),
        .IDLE_PAT (IDLE_PAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_obs(input logic [2:0] p, input int s, input logic b, input logic d);
        obs_t e;
        e.pat  = p;
        e.step = 3'(s);
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int n, input logic first_done);
        for (int i = 0; i < n; i++) begin
            push_obs(IDLE_PAT, 0, 1'b0, (i == 0) ? first_done : 1'b0);
        end
    endtask

    // Expand a run from the model table; limit > 0 truncates (used for infinite runs).
    task automatic push_run(input int len, input int nl, input int limit);
        int cnt = 0;
        int p   = 0;
        bit cut = 1'b0;
        while (!cut && (nl == 0 || p < nl)) begin
            for (int s = 0; s <= len; s++) begin
                for (int d = 0; d <= m_dwell[s]; d++) begin
                    if (limit > 0 && cnt >= limit) begin
                        cut = 1'b1;
                    end else begin
                        push_obs(m_pat[s], s, 1'b1, 1'b0);
                        cnt++;
                    end
                end
            end
            p++;
        end
        if (nl != 0) begin
            push_idle(2, 1'b1);
        end
    endtask

    task automatic start_run(input int len, input int nl, input int limit);
        bus.cfg_len = 3'(len);
        bus.loops   = 4'(nl);
        bus.start   = 1'b1;
        push_run(len, nl, limit);
    endtask

    task automatic write_entry(input int a, input logic [2:0] p, input int dw);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(a);
        bus.cfg_pat   = p;
        bus.cfg_dwell = 8'(dw);
        @(posedge clk);
        #1;
        bus.cfg_we    = 1'b0;
        m_pat[a]      = p;
        m_dwell[a]    = dw;
    endtask

    // Advance n clocks; single-cycle strobes are dropped after each edge.
    task automatic run_check(input int n, input string tag);
        obs_t got;
        obs_t exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            bus.stop   = 1'b0;
            bus.cfg_we = 1'b0;
            got = {bus.pat, bus.step, bus.busy, bus.done};
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL %s: observed pat=%b step=%0d busy=%b done=%b, expected sample queue non-empty",
                       tag, got.pat, got.step, got.busy, got.done);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                assert (got === exp) else begin
                    n_fail++;
                    $error("FAIL %s cyc%0d: observed pat=%b step=%0d busy=%b done=%b, expected pat=%b step=%0d busy=%b done=%b",
                           tag, i, got.pat, got.step, got.busy, got.done,
                           exp.pat, exp.step, exp.busy, exp.done);
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 3'd0;
        bus.cfg_pat   = 3'd0;
        bus.cfg_dwell = 8'd0;
        bus.cfg_len   = 3'd0;
        bus.loops     = 4'd0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_pat[i]   = 3'd0;
            m_dwell[i] = 0;
        end

        // Reset state, during and after reset.
        push_idle(2, 1'b0);
        run_check(1, "reset_hold");
        rst = 1'b0;
        run_check(1, "reset_release");

        write_entry(0, 3'b111, 0);
        write_entry(1, 3'b000, 2);
        write_entry(2, 3'b010, 1);

        // Basic single pass: 1+3+2 busy cycles then done.
        start_run(2, 1, 0);
        run_check(8, "basic");

        // Three passes back to back: 18 busy cycles then one done.
        start_run(2, 3, 0);
        run_check(20, "multi_loop");

        // Write to entry 1 while running is dropped.
        start_run(2, 1, 0);
        run_check(2, "lockout_a");
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'd1;
        bus.cfg_pat   = 3'b011;
        bus.cfg_dwell = 8'd5;
        run_check(6, "lockout_b");
        start_run(2, 1, 0);
        run_check(8, "lockout_after");

        // Infinite run aborted after 40 cycles.
        start_run(2, 0, 40);
        run_check(40, "infinite");
        bus.stop = 1'b1;
        push_idle(2, 1'b0);
        run_check(2, "abort");

        // start and stop together in IDLE: nothing happens.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        push_idle(2, 1'b0);
        run_check(2, "collision");

        // A second start while running is ignored.
        start_run(2, 1, 0);
        run_check(3, "restart_a");
        bus.start = 1'b1;
        run_check(5, "restart_b");

        // Reset at step 1 clears outputs and the table on the same edge.
        start_run(2, 1, 0);
        run_check(2, "midrst_run");
        rst = 1'b1;
        sb.delete();
        push_idle(1, 1'b0);
        run_check(1, "midrst");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_pat[i]   = 3'd0;
            m_dwell[i] = 0;
        end

        // Write and start in one cycle: step 0 plays the cleared entry.
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_pat   = 3'b110;
        bus.cfg_dwell = 8'd0;
        start_run(0, 1, 0);
        run_check(3, "wr_start");
        m_pat[0] = 3'b110;
        start_run(0, 1, 0);
        run_check(3, "wr_landed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_seq_ctrl.md
# pattern_seq_ctrl

Programmable sequencer for the 3-bit pattern output.
- Steps a 3-bit value through a small register table of up to 8 entries.
- Each entry carries its own dwell time.
- The whole sequence repeats a configured number of times, or forever.
- Sits between a configuration/command source (start/stop plus table writes) and the consumer of the 3-bit pattern bus, which it drives directly.

## Interface
Parameters:
- DEPTH, 8: number of table entries; must be a power of two, ≤ 16.
- DWELL_W, 8: width of per-step dwell count.
- LOOP_W, 4: width of loop count.
- IDLE_PAT, 3'b101: value driven on `pat` when not running.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- cfg_we, in, 1: table write strobe.
- cfg_addr, in, $clog2(DEPTH): table entry index.
- cfg_pat, in, 3: pattern value for entry.
- cfg_dwell, in, DWELL_W: extra hold cycles for entry.
- cfg_len, in, $clog2(DEPTH): index of last step; sampled at start.
- loops, in, LOOP_W: sequence repetitions; 0 = infinite; sampled at start.
- start, in, 1: begin sequence (level sampled each cycle).
- stop, in, 1: abort sequence.
- pat, out, 3: pattern output, registered.
- step, out, $clog2(DEPTH): current table index, registered.
- busy, out, 1: high while RUN.
- done, out, 1: one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE: outputs idle.
  - RUN: stepping through the table.
  - DONE: one cycle; asserts `done`.
- IDLE → RUN on `start` && !`stop`:
  - latch `cfg_len` and `loops`.
  - `pat` ← table[0].pat, `step` ← 0, dwell counter ← table[0].dwell, loop counter ← `loops`.
- In RUN, each step lasts dwell+1 cycles; dwell 0 = one cycle.
  - While dwell counter ≠ 0: decrement and hold.
  - At 0, if `step` < len: advance `step` and load next entry's pat/dwell.
  - At 0 with `step` == len (end of pass):
    - latched loops == 0: wrap to step 0 indefinitely.
    - loop counter > 1: decrement loop counter and wrap to step 0.
    - loop counter == 1: go to DONE.
- DONE: `pat` ← IDLE_PAT, `step` ← 0, `busy` ← 0, `done` ← 1 for exactly one cycle, then IDLE.
- `stop` in RUN: next edge → IDLE, `pat` ← IDLE_PAT, `step` ← 0, no `done` pulse.
- `stop` wins over `start` when both are high in IDLE; nothing happens.
- `start` in RUN or DONE is ignored; it does not restart.
- Table writes:
  - Accepted only when `busy` == 0, i.e. in IDLE or DONE.
  - Ignored in RUN; the table is stable while sequencing.
- Write and start in the same IDLE cycle: the write lands, but step 0 uses the pre-write table contents.
- Wrap from step len to step 0 costs no extra cycle; `pat` is continuous across passes.
- Arithmetic:
  - Counters are unsigned.
  - The dwell counter never underflows; it is reloaded at 0.
  - The loop counter is never decremented below 1.

## Timing
- Reset values: `pat` = IDLE_PAT, `step` = 0, `busy` = 0, `done` = 0, state IDLE, all table entries pat = 0 and dwell = 0.
- Reset mid-run returns every output and the table to reset values on the same edge.
- Latency:
  - `start` sampled at edge N → `pat` = table[0].pat and `busy` = 1 after edge N.
  - `stop` sampled at edge M → `pat` = IDLE_PAT and `busy` = 0 after edge M.
- Total run cycles for finite L loops: L × Σ(dwell_i + 1) for i = 0..len, followed by one DONE cycle.
- `busy` and `done` are never high together.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `pattern_seq_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - default IDLE_PAT.
  - entry struct {pat[2:0], dwell[DWELL_W-1:0]}.
- Sub-module `pattern_table`:
  - DEPTH-entry register file with synchronous write, gated by `!busy`.
  - asynchronous read port indexed by next-step address.
  - reset-clears all entries.
- Top holds the FSM, the dwell counter, the loop counter and the output registers.

## Test plan
- Basic pass:
  - Stimulus: write entries 0..2 = (3'b111, dwell 0), (3'b000, dwell 2), (3'b010, dwell 1); cfg_len = 2, loops = 1; pulse start.
  - Required: `pat` = 111 for 1 cycle, 000 for 3, 010 for 2; then a `done` pulse with `pat` = 101; `busy` high for exactly 6 cycles.
- Multi-loop:
  - Stimulus: same table, loops = 3.
  - Required: the 6-cycle sequence repeats 3 times with no gap; a single `done` pulse after cycle 18.
- Infinite and abort:
  - Stimulus: loops = 0; stop asserted at cycle 40.
  - Required: sequence wraps continuously; next edge gives `pat` = 101, `busy` = 0; no `done`.
- Write lockout:
  - Stimulus: during RUN, write entry 1 = 3'b011.
  - Required: output unchanged.
  - Follow-up: after `done`, start again; entry 1 still 000.
- Start/stop collision and restart:
  - Stimulus: start and stop high together in IDLE; then start asserted again while busy.
  - Required: no run begins on the collision; the second start is ignored with no restart and no change to `step`.
- Reset mid-run:
  - Stimulus: assert rst at step 1.
  - Required: next edge `pat` = 101, `step` = 0, `busy` = 0; a subsequent start plays cleared table entry 0 (`pat` = 000 for 1 cycle).
